// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// scoreboard_pkg : shared widths, types and op encoding for reg_scoreboard
// Revision: 1.0
// ============================================================================
package scoreboard_pkg;

  localparam int NUM_REGS_DEFAULT     = 32;
  localparam int MAX_INFLIGHT_DEFAULT = 3;

  function automatic int addr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int cnt_width(input int max_inflight);
    return (max_inflight > 0) ? $clog2(max_inflight + 1) : 1;
  endfunction

  localparam int REG_ADDR_W = addr_width(NUM_REGS_DEFAULT);
  localparam int PEND_CNT_W = cnt_width(MAX_INFLIGHT_DEFAULT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PEND_CNT_W-1:0] pend_cnt_t;

  typedef enum logic [1:0] {
    SB_NONE = 2'd0,
    SB_INC  = 2'd1,
    SB_DEC  = 2'd2,
    SB_HOLD = 2'd3
  } sb_op_e;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// scoreboard_entry : pending-write counter for one architectural register
// Revision: 1.0
// ============================================================================
module scoreboard_entry
  import scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = cnt_width(MAX_INFLIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             pending_next,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  sb_op_e           op;
  logic [CNT_W-1:0] cnt_next;

  assign zero = (cnt == '0);
  assign full = (cnt == MAX_CNT);

  always_comb begin
    case ({dec, inc})
      2'b01:   op = SB_INC;
      2'b10:   op = SB_DEC;
      2'b11:   op = SB_HOLD;
      default: op = SB_NONE;
    endcase
  end

  // A retire with nothing pending is an error even when paired with an issue.
  always_comb begin
    cnt_next  = cnt;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (clear) begin
      cnt_next = '0;
    end else begin
      case (op)
        SB_INC: begin
          if (full) overflow = 1'b1;
          else      cnt_next = cnt + 1'b1;
        end
        SB_DEC: begin
          if (zero) underflow = 1'b1;
          else      cnt_next = cnt - 1'b1;
        end
        SB_HOLD: begin
          if (zero) underflow = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pending_next = (cnt_next != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard : per-register pending-write scoreboard gating s0 issue
// Revision: 1.0
// ============================================================================
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 3,
  parameter int WB_BYPASS    = 1,
  parameter int STALL_W      = 32,
  localparam int ADDR_W      = addr_width(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ADDR_W-1:0]  issue_rs1,
  input  logic               issue_rs1_en,
  input  logic [ADDR_W-1:0]  issue_rs2,
  input  logic               issue_rs2_en,
  input  logic [ADDR_W-1:0]  issue_rd,
  input  logic               issue_rd_we,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_rd,
  input  logic               flush,
  output logic               data_dependency,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count,
  output logic               sb_error
);

  localparam int               CNT_W   = cnt_width(MAX_INFLIGHT);
  localparam int               TBL     = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] cnt [TBL];
  logic [TBL-1:0]   zero_v;
  logic [TBL-1:0]   full_v;
  logic [TBL-1:0]   pend_next_v;
  logic [TBL-1:0]   unf_v;
  logic [TBL-1:0]   ovf_v;

  logic accept;
  logic rs1_haz;
  logic rs2_haz;
  logic struct_stall;

  // Slot 0 (x0) and any address beyond NUM_REGS are never pending.
  for (genvar r = 0; r < TBL; r++) begin : g_reg
    if (r == 0 || r >= NUM_REGS) begin : g_const
      assign cnt[r]         = '0;
      assign zero_v[r]      = 1'b1;
      assign full_v[r]      = 1'b0;
      assign pend_next_v[r] = 1'b0;
      assign unf_v[r]       = 1'b0;
      assign ovf_v[r]       = 1'b0;
    end else begin : g_entry
      logic inc;
      logic dec;
      assign inc = accept & issue_rd_we & (issue_rd == ADDR_W'(r));
      assign dec = wb_valid & ~flush & (wb_rd == ADDR_W'(r));
      scoreboard_entry #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
      ) u_entry (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc          (inc),
        .dec          (dec),
        .clear        (flush),
        .cnt          (cnt[r]),
        .zero         (zero_v[r]),
        .full         (full_v[r]),
        .pending_next (pend_next_v[r]),
        .underflow    (unf_v[r]),
        .overflow     (ovf_v[r])
      );
    end
  end

  logic rs1_pend, rs1_byp, rs2_pend, rs2_byp, rd_retire;

  assign rs1_pend = issue_rs1_en & (issue_rs1 != '0) & ~zero_v[issue_rs1];
  assign rs2_pend = issue_rs2_en & (issue_rs2 != '0) & ~zero_v[issue_rs2];
  assign rs1_byp  = (WB_BYPASS != 0) & wb_valid & (wb_rd == issue_rs1) & (cnt[issue_rs1] == ONE_CNT);
  assign rs2_byp  = (WB_BYPASS != 0) & wb_valid & (wb_rd == issue_rs2) & (cnt[issue_rs2] == ONE_CNT);
  assign rs1_haz  = rs1_pend & ~rs1_byp;
  assign rs2_haz  = rs2_pend & ~rs2_byp;

  // A full rd may still issue when the same cycle frees one of its slots.
  assign rd_retire    = wb_valid & (wb_rd == issue_rd);
  assign struct_stall = issue_rd_we & (issue_rd != '0) & full_v[issue_rd] & ~rd_retire;

  assign data_dependency = issue_valid & (rs1_haz | rs2_haz);
  assign issue_ready     = ~flush & ~(rs1_haz | rs2_haz) & ~struct_stall;
  assign accept          = issue_valid & issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      stall_count <= '0;
      sb_error    <= 1'b0;
    end else begin
      busy     <= |pend_next_v;
      sb_error <= sb_error | (|unf_v) | (|ovf_v);
      if (issue_valid & ~issue_ready & ~flush & ~(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_reg_scoreboard : directed checks of reg_scoreboard (bypass on and off)
// Revision: 1.0
// ============================================================================
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid, issue_rs1_en, issue_rs2_en, issue_rd_we;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       wb_valid, flush;
  logic [4:0] wb_rd;

  logic        ready_b, dd_b, busy_b, err_b;
  logic [31:0] stall_b;
  logic        ready_n, dd_n, busy_n, err_n;
  logic [31:0] stall_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(3), .WB_BYPASS(1), .STALL_W(32)) dut (
    .clk (clk), .rst_n (rst_n),
    .issue_valid (issue_valid), .issue_ready (ready_b),
    .issue_rs1 (issue_rs1), .issue_rs1_en (issue_rs1_en),
    .issue_rs2 (issue_rs2), .issue_rs2_en (issue_rs2_en),
    .issue_rd (issue_rd), .issue_rd_we (issue_rd_we),
    .wb_valid (wb_valid), .wb_rd (wb_rd), .flush (flush),
    .data_dependency (dd_b), .busy (busy_b),
    .stall_count (stall_b), .sb_error (err_b)
  );

  reg_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(3), .WB_BYPASS(0), .STALL_W(32)) dut_nb (
    .clk (clk), .rst_n (rst_n),
    .issue_valid (issue_valid), .issue_ready (ready_n),
    .issue_rs1 (issue_rs1), .issue_rs1_en (issue_rs1_en),
    .issue_rs2 (issue_rs2), .issue_rs2_en (issue_rs2_en),
    .issue_rd (issue_rd), .issue_rd_we (issue_rd_we),
    .wb_valid (wb_valid), .wb_rd (wb_rd), .flush (flush),
    .data_dependency (dd_n), .busy (busy_n),
    .stall_count (stall_n), .sb_error (err_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs1_en = 1'b0; issue_rs2_en = 1'b0; issue_rd_we = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'b0, busy_b}, 32'd0);
    chk("rst_stall", stall_b, 32'd0);
    chk("rst_err",   {31'b0, err_b}, 32'd0);
    chk("rst_ready", {31'b0, ready_b}, 32'd1);
    rst_n = 1'b1;
    step();

    // 1: RAW hazard on x5
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_we = 1'b1;
    #1 chk("t1_issue_ready", {31'b0, ready_b}, 32'd1);
    step();
    chk("t1_busy", {31'b0, busy_b}, 32'd1);
    issue_rd_we = 1'b0; issue_rd = '0; issue_rs1 = 5'd5; issue_rs1_en = 1'b1;
    #1;
    chk("t1_dd",    {31'b0, dd_b}, 32'd1);
    chk("t1_ready", {31'b0, ready_b}, 32'd0);
    step();
    chk("t1_stall", stall_b, 32'd1);

    // 2: same-cycle writeback bypass vs no bypass
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    chk("t2_byp_ready",  {31'b0, ready_b}, 32'd1);
    chk("t2_byp_dd",     {31'b0, dd_b}, 32'd0);
    chk("t2_nobyp_ready", {31'b0, ready_n}, 32'd0);
    step();
    chk("t2_busy",        {31'b0, busy_b}, 32'd0);
    chk("t2_stall",       stall_b, 32'd1);
    chk("t2_nobyp_stall", stall_n, 32'd2);
    wb_valid = 1'b0;
    #1 chk("t2_nobyp_ready_next", {31'b0, ready_n}, 32'd1);
    step();

    // 3: x0 is never tracked
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rd_we = 1'b1;
    step();
    chk("t3_busy_w", {31'b0, busy_b}, 32'd0);
    issue_rd_we = 1'b0; issue_rs2 = 5'd0; issue_rs2_en = 1'b1;
    #1;
    chk("t3_ready", {31'b0, ready_b}, 32'd1);
    chk("t3_dd",    {31'b0, dd_b}, 32'd0);
    step();
    chk("t3_busy_r", {31'b0, busy_b}, 32'd0);

    // 4: MAX_INFLIGHT writes to x7
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_fill_ready", {31'b0, ready_b}, 32'd1);
      step();
    end
    chk("t4_busy", {31'b0, busy_b}, 32'd1);
    #1;
    chk("t4_full_ready", {31'b0, ready_b}, 32'd0);
    chk("t4_full_dd",    {31'b0, dd_b}, 32'd0);
    step();
    chk("t4_stall", stall_b, 32'd2);
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1 chk("t4_full_retire_ready", {31'b0, ready_b}, 32'd1);
    step();
    idle();
    issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rs1_en = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
    #1 chk("t4_cnt3_dd", {31'b0, dd_b}, 32'd1);
    step();
    chk("t4_stall2", stall_b, 32'd3);
    issue_valid = 1'b0;
    step();
    issue_valid = 1'b1;
    #1;
    chk("t4_cnt1_byp_ready", {31'b0, ready_b}, 32'd1);
    chk("t4_cnt1_byp_dd",    {31'b0, dd_b}, 32'd0);
    step();
    chk("t4_drained_busy", {31'b0, busy_b}, 32'd0);
    chk("t4_no_err",       {31'b0, err_b}, 32'd0);

    // 5: underflow on x9
    idle();
    wb_valid = 1'b1; wb_rd = 5'd9;
    step();
    chk("t5_err",  {31'b0, err_b}, 32'd1);
    chk("t5_busy", {31'b0, busy_b}, 32'd0);
    idle();
    step();
    step();
    chk("t5_err_sticky", {31'b0, err_b}, 32'd1);
    issue_valid = 1'b1; issue_rs1 = 5'd9; issue_rs1_en = 1'b1;
    #1 chk("t5_x9_ready", {31'b0, ready_b}, 32'd1);
    step();

    // 6: flush drops pending x3/x4
    idle();
    issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    chk("t6_busy", {31'b0, busy_b}, 32'd1);
    issue_rd_we = 1'b0; issue_rd = '0;
    issue_rs1 = 5'd3; issue_rs1_en = 1'b1; issue_rs2 = 5'd4; issue_rs2_en = 1'b1;
    flush = 1'b1;
    #1 chk("t6_flush_ready", {31'b0, ready_b}, 32'd0);
    step();
    chk("t6_flush_busy",  {31'b0, busy_b}, 32'd0);
    chk("t6_flush_stall", stall_b, 32'd3);
    flush = 1'b0;
    #1;
    chk("t6_post_ready", {31'b0, ready_b}, 32'd1);
    chk("t6_post_dd",    {31'b0, dd_b}, 32'd0);
    step();
    chk("t6_post_stall", stall_b, 32'd3);

    // asynchronous reset mid-run
    idle();
    issue_valid = 1'b1; issue_rd = 5'd6; issue_rd_we = 1'b1;
    step();
    chk("r_busy_pre", {31'b0, busy_b}, 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy",  {31'b0, busy_b}, 32'd0);
    chk("r_stall", stall_b, 32'd0);
    chk("r_err",   {31'b0, err_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue_valid = 1'b1; issue_rs1 = 5'd6; issue_rs1_en = 1'b1;
    #1 chk("r_x6_ready", {31'b0, ready_b}, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
